bitnet_result_wr_dma: RTL and testbench
=======================================

# bitnet_result_wr_dma

Write-direction AXI4 master DMA that drains the BitNet engine's result stream into DDR at the host-programmed output address. Counterpart to the engine's read path: it turns a valid/ready beat stream into 4 KB-safe INCR bursts on the AW/W/B channels, tracks write responses and reports busy/done/error to the register block and interrupt controller. It keeps one burst outstanding at a time.

## Interface
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 64, AXI data width; beat = DATA_WIDTH/8 bytes (8)
- ID_WIDTH, 4, AXI ID width; awid driven all-zero
- MAX_BURST, 256, max beats per burst (1..256)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  byte address of first beat; low log2(DATA_WIDTH/8) bits ignored
- total_beats  in  32  beats to write; sampled with start
- s_data  in  DATA_WIDTH  result beat
- s_valid  in  1  result beat valid
- s_ready  out  1  result beat accepted when s_valid & s_ready
- m_axi_awid/awaddr/awlen/awsize/awburst/awvalid  out  ID/ADDR/8/3/2/1  AW channel; awsize = log2(DATA_WIDTH/8), awburst = 2'b01
- m_axi_awready  in  1
- m_axi_wdata/wstrb/wlast/wvalid  out  DATA/DATA/8/1/1  W channel; wstrb all ones
- m_axi_wready  in  1
- m_axi_bresp  in  2;  m_axi_bvalid  in  1;  m_axi_bready  out  1
- busy  out  1  high from accepted start until done pulse
- done  out  1  one-cycle completion pulse
- error  out  1  sticky: any bresp != 2'b00 in current job; cleared by next start
- beats_written  out  32  beats acknowledged by OKAY/any B response so far

## Operation
- FSM: IDLE, ADDR, DATA, RESP, DONE.
- IDLE: start latches addr (aligned down), remaining = total_beats, clears error/beats_written. total_beats == 0 -> DONE; else -> ADDR.
- ADDR: len = min(remaining, MAX_BURST, (4096 - addr[11:0]) / bytes_per_beat); awaddr = addr, awlen = len-1, awvalid = 1, held stable until awready; -> DATA.
- DATA: wvalid = s_valid, s_ready = m_axi_wready, wdata = s_data (combinational pass-through); beat counter increments per W handshake; wlast = (beat_cnt == len-1); on last handshake -> RESP.
- RESP: bready = 1; on bvalid: beats_written += len, remaining -= len, addr += len*bytes_per_beat, error |= (bresp != 0); remaining == 0 -> DONE else -> ADDR.
- DONE: done = 1 for one cycle, -> IDLE; busy drops same edge done drops.
- start outside IDLE ignored. s_ready = 0 and wvalid = 0 outside DATA.

## Timing
- Reset values: all valid/ready outputs 0, awaddr/awlen/wdata 0, busy 0, done 0, error 0, beats_written 0, state IDLE.
- start at edge N -> awvalid high from edge N+1 (ADDR). awready seen at edge M -> first wvalid possible from M+1.
- W throughput: 1 beat/cycle when s_valid & wready continuously; bubbles pass through unregistered.
- bvalid at edge K -> next awvalid at K+1 or done at K+1.
- total_beats == 0: done at start+2 edges, no AXI activity.
- 4 KB boundary: burst never crosses; addr 0xFF8 with 4 beats -> bursts of 1 then 3.
- rst mid-operation: all outputs return to reset values immediately; in-flight burst abandoned, no wlast or B completion.

## Configuration
- VIBEE_WR_DMA_ERR_ABORT_EN defined: a non-OKAY bresp moves RESP -> DONE immediately, remaining bursts not issued, error set, beats_written includes the failed burst.
- Undefined: errors recorded in sticky error only; all bursts complete.

## Test plan
- base 0x1000, total 4, slave always ready -> one AW awlen=3 at 0x1000, 4 W beats, wlast on 4th, done, beats_written=4, error=0.
- total 600, base 0x0 -> AW bursts awlen 255/255/87 at 0x0/0x800/0x1000, done after third B.
- base 0xFF8, total 4 -> AW 0xFF8 awlen=0 then 0x1000 awlen=2; no 4 KB crossing.
- s_valid toggling, wready random stalls -> wdata order preserved, no extra/missing beats, wlast exactly on final beat.
- bresp=2'b10 on first of 3 bursts -> error=1; with ERR_ABORT_EN done after 1 burst (beats_written=256), without after all 3.
- rst asserted during DATA beat 5 -> awvalid/wvalid/busy low immediately; new start after release runs clean job from zero.

Source files
------------

// File: rtl/bitnet_result_wr_dma.sv
// bitnet_result_wr_dma: AXI4 write-master DMA that drains the result stream into DDR
// using 4 KB-safe INCR bursts, one outstanding. Option macro: VIBEE_WR_DMA_ERR_ABORT_EN.
`default_nettype none

module bitnet_result_wr_dma #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_BURST  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [31:0]             total_beats,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [31:0]             beats_written
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BYTES - 1));

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_RESP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [31:0]             remaining;
    logic [8:0]              len;
    logic [8:0]              beat_cnt;
    logic [31:0]             page_beats;
    logic [31:0]             burst_len32;
    logic [8:0]              burst_len;
    logic                    beat_last;
    logic                    w_fire;

    // Beats left before the next 4 KB page; the burst is clipped to this.
    always_comb begin
        page_beats  = 32'((13'd4096 - {1'b0, addr[11:0]}) >> SIZE);
        burst_len32 = remaining;
        if (32'(MAX_BURST) < burst_len32) burst_len32 = 32'(MAX_BURST);
        if (page_beats < burst_len32)     burst_len32 = page_beats;
    end

    assign burst_len = burst_len32[8:0];
    assign beat_last = (beat_cnt == len - 9'd1);
    assign w_fire    = (state == S_DATA) && s_valid && m_axi_wready;

    assign m_axi_awid    = '0;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awaddr  = addr;
    assign m_axi_awlen   = (state == S_ADDR) ? 8'(burst_len - 9'd1) : 8'd0;
    assign m_axi_wstrb   = '1;
    assign m_axi_wdata   = (state == S_DATA) ? s_data : '0;
    assign m_axi_wlast   = (state == S_DATA) && beat_last;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        s_ready       = 1'b0;
        m_axi_bready  = 1'b0;
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (total_beats == 32'd0) ? S_DONE : S_ADDR;
            end
            S_ADDR: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_nxt = S_DATA;
            end
            S_DATA: begin
                m_axi_wvalid = s_valid;
                s_ready      = m_axi_wready;
                if (w_fire && beat_last) state_nxt = S_RESP;
            end
            S_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    if (remaining == 32'(len)) state_nxt = S_DONE;
                    else                       state_nxt = S_ADDR;
`ifdef VIBEE_WR_DMA_ERR_ABORT_EN
                    if (m_axi_bresp != 2'b00)  state_nxt = S_DONE;
`endif
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr          <= '0;
            remaining     <= '0;
            len           <= '0;
            beat_cnt      <= '0;
            error         <= 1'b0;
            beats_written <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr          <= base_addr & ALIGN_MASK;
                        remaining     <= total_beats;
                        error         <= 1'b0;
                        beats_written <= '0;
                    end
                end
                S_ADDR: begin
                    if (m_axi_awready) begin
                        len      <= burst_len;
                        beat_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (w_fire) beat_cnt <= beat_last ? 9'd0 : beat_cnt + 9'd1;
                end
                S_RESP: begin
                    if (m_axi_bvalid) begin
                        beats_written <= beats_written + 32'(len);
                        remaining     <= remaining - 32'(len);
                        addr          <= addr + (ADDR_WIDTH'(len) << SIZE);
                        if (m_axi_bresp != 2'b00) error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bitnet_result_wr_dma.sv
// tb_bitnet_result_wr_dma: directed bench with a reactive AXI slave and result-stream source.
`default_nettype none

module tb_bitnet_result_wr_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] base_addr;
    logic [31:0] total_beats;
    logic [63:0] s_data;
    logic        s_valid, s_ready;
    logic [3:0]  awid;
    logic [63:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        busy, done, error;
    logic [31:0] beats_written;

    bitnet_result_wr_dma dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .total_beats(total_beats),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .busy(busy), .done(done), .error(error), .beats_written(beats_written)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [63:0] w_data_q[$];
    bit          w_last_q[$];
    int          b_cnt;
    bit          attr_bad;
    bit          hs_s, hs_wlast, hs_b;
    int          data_idx, n_src, b_idx, err_burst;
    logic [31:0] job_id;
    bit          stall_en, toggle_en, pend_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshakes are recorded mid-cycle; they complete at the following rising edge.
    always @(negedge clk) begin
        hs_s      = s_valid & s_ready & ~rst;
        hs_wlast  = wvalid & wready & wlast & ~rst;
        hs_b      = bvalid & bready & ~rst;
        if (!rst) begin
            if (awvalid && awready) begin
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(awlen);
                if (awid !== 4'd0 || awsize !== 3'd3 || awburst !== 2'b01) attr_bad = 1'b1;
            end
            if (wvalid && wready) begin
                w_data_q.push_back(wdata);
                w_last_q.push_back(wlast);
                if (wstrb !== 8'hFF) attr_bad = 1'b1;
            end
            if (hs_b) b_cnt++;
        end
    end

    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        s_valid = 1'b0; s_data = '0; pend_b = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bvalid = 1'b0; pend_b = 1'b0; s_valid = 1'b0;
            end else begin
                if (hs_s)     data_idx++;
                if (hs_b)     bvalid = 1'b0;
                if (hs_wlast) pend_b = 1'b1;
                if (pend_b && !bvalid) begin
                    bvalid = 1'b1;
                    bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
                    b_idx++;
                    pend_b = 1'b0;
                end
                awready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
                wready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_valid = (data_idx < n_src) && (toggle_en ? ($urandom_range(0, 2) != 0) : 1'b1);
                s_data  = {job_id, 32'(data_idx)};
            end
        end
    end

    task automatic start_job(input logic [63:0] base, input int total, input logic [31:0] jid,
                             input bit stall, input bit toggle, input int errb);
        aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_last_q.delete();
        b_cnt = 0; attr_bad = 1'b0; data_idx = 0; b_idx = 0; n_src = total;
        job_id = jid; stall_en = stall; toggle_en = toggle; err_burst = errb;
        base_addr = base; total_beats = 32'(total);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic check_job(input int n_aw, input logic [63:0] a0, input logic [63:0] a1,
                             input logic [63:0] a2, input int l0, input int l1, input int l2,
                             input int nbeats, input int exp_bw, input bit exp_err);
        logic [63:0] ea[3];
        int          el[3];
        int          bad_d = 0, bad_l = 0, acc = 0, k = 0;
        ea[0] = a0; ea[1] = a1; ea[2] = a2;
        el[0] = l0; el[1] = l1; el[2] = l2;
        check("aw_count", 64'(aw_addr_q.size()), 64'(n_aw));
        for (int i = 0; i < n_aw && i < aw_addr_q.size(); i++) begin
            check("aw_addr", aw_addr_q[i], ea[i]);
            check("aw_len", 64'(aw_len_q[i]), 64'(el[i] - 1));
        end
        check("w_beats", 64'(w_data_q.size()), 64'(nbeats));
        for (int i = 0; i < w_data_q.size(); i++) begin
            bit exp_last;
            if (w_data_q[i] !== {job_id, 32'(i)}) bad_d++;
            exp_last = (k < 3) && (i == acc + el[k] - 1);
            if (w_last_q[i] !== exp_last) bad_l++;
            if (exp_last) begin
                acc = acc + el[k];
                k++;
            end
        end
        check("w_data_order", 64'(bad_d), 64'd0);
        check("wlast_pos", 64'(bad_l), 64'd0);
        check("b_count", 64'(b_cnt), 64'(n_aw));
        check("beats_written", 64'(beats_written), 64'(exp_bw));
        check("error", 64'(error), 64'(exp_err));
        check("axi_attrs", 64'(attr_bad), 64'd0);
    endtask

    initial begin
        int  nlast;
        rst = 1'b1; start = 1'b0; base_addr = '0; total_beats = '0;
        n_src = 0; data_idx = 0; b_idx = 0; err_burst = -1; job_id = '0;
        stall_en = 1'b0; toggle_en = 1'b0; b_cnt = 0; attr_bad = 1'b0;
        repeat (3) @(posedge clk);
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("reset_valids", {60'd0, awvalid, wvalid, s_ready, bready}, 64'd0);
        check("reset_status", {61'd0, busy, done, error}, 64'd0);
        check("reset_beats_written", 64'(beats_written), 64'd0);
        check("reset_awaddr", awaddr, 64'd0);
        check("reset_awlen", 64'(awlen), 64'd0);

        // Single short burst; unaligned base is rounded down.
        start_job(64'h1003, 4, 32'd1, 1'b0, 1'b0, -1);
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'd1);
        wait_done(200);
        check_job(1, 64'h1000, 64'h0, 64'h0, 4, 0, 0, 4, 4, 1'b0);

        // MAX_BURST split followed by page-limited and tail bursts.
        start_job(64'h0, 600, 32'd2, 1'b0, 1'b0, -1);
        wait_done(2000);
        check_job(3, 64'h0, 64'h800, 64'h1000, 256, 256, 88, 600, 600, 1'b0);

        start_job(64'hFF8, 4, 32'd3, 1'b0, 1'b0, -1);
        wait_done(200);
        check_job(2, 64'hFF8, 64'h1000, 64'h0, 1, 3, 0, 4, 4, 1'b0);

        // Source bubbles and slave stalls.
        start_job(64'h4000, 40, 32'd4, 1'b1, 1'b1, -1);
        wait_done(3000);
        check_job(1, 64'h4000, 64'h0, 64'h0, 40, 0, 0, 40, 40, 1'b0);

        // SLVERR on the first of three bursts.
        start_job(64'h10000, 600, 32'd5, 1'b0, 1'b0, 0);
        wait_done(2000);
`ifdef VIBEE_WR_DMA_ERR_ABORT_EN
        check_job(1, 64'h10000, 64'h0, 64'h0, 256, 0, 0, 256, 256, 1'b1);
`else
        check_job(3, 64'h10000, 64'h10800, 64'h11000, 256, 256, 88, 600, 600, 1'b1);
`endif

        // Zero-length job: clears sticky error, no AXI activity.
        start_job(64'h5000, 0, 32'd6, 1'b0, 1'b0, -1);
        @(negedge clk);
        check("zero_done", 64'(done), 64'd1);
        check("zero_error_cleared", 64'(error), 64'd0);
        check("zero_beats_written", 64'(beats_written), 64'd0);
        @(negedge clk);
        check("zero_done_drop", {62'd0, done, busy}, 64'd0);
        check("zero_no_aw", 64'(aw_addr_q.size()), 64'd0);

        // Asynchronous reset while the fifth beat is on the W channel.
        start_job(64'h2000, 16, 32'd7, 1'b0, 1'b0, -1);
        for (int i = 0; i < 200 && w_data_q.size() < 5; i++) @(negedge clk);
        check("rst_reach_beat5", 64'(w_data_q.size()), 64'd5);
        #1 rst = 1'b1;
        #1;
        check("midrst_valids", {61'd0, awvalid, wvalid, s_ready}, 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_beats_written", 64'(beats_written), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nlast = 0;
        foreach (w_last_q[i]) if (w_last_q[i]) nlast++;
        check("midrst_no_wlast", 64'(nlast), 64'd0);
        check("midrst_no_b", 64'(b_cnt), 64'd0);

        start_job(64'h3000, 4, 32'd8, 1'b0, 1'b0, -1);
        wait_done(200);
        check_job(1, 64'h3000, 64'h0, 64'h0, 4, 0, 0, 4, 4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
